alu_cmd_loader: RTL and testbench
=================================

Name: alu_cmd_loader

Overview:
- Upstream command stage for the ALU.
- Receives a word-serial command stream of the form {opcode, operand1, operand2} over a valid/ready handshake.
- Assembles the three words into one ALU command and presents in1/in2/op/invalid_data as registered outputs under an issue valid/ready handshake.
- Detects framing errors and opcodes that are out of range; out-of-range opcodes are flagged on invalid_data so the ALU asserts error.

Parameters:
- WIDTH, 8, operand and stream word width; minimum legal value 4.
- NUM_OPS, 4, number of legal opcodes; any op >= NUM_OPS is invalid.
- CNT_W, 8, width of the saturating frame-error counter.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- s_data  in  WIDTH  command stream word.
- s_sof  in  1  start of frame; high on the opcode word only.
- s_valid  in  1  s_data/s_sof are valid.
- s_ready  out  1  loader accepts a word this cycle.
- in1  out  WIDTH  signed operand 1 to the ALU.
- in2  out  WIDTH  signed operand 2 to the ALU.
- op  out  4  ALU opcode.
- invalid_data  out  1  command is invalid; the ALU must flag error.
- issue_valid  out  1  command on in1/in2/op/invalid_data is valid.
- issue_ready  in  1  consumer accepts the command.
- frame_err_cnt  out  CNT_W  saturating count of framing errors.

Behaviour:
- Reset: clk with rst_n=0 gives:
  - state=IDLE;
  - in1=0, in2=0, op=0, invalid_data=0, issue_valid=0, frame_err_cnt=0.
  - s_ready is 0 while rst_n=0.
- Accept: a word is accepted when s_valid && s_ready at a rising edge.
- s_ready is combinational from state: 1 in IDLE, GET_A and GET_B; 0 in ISSUE.
- States:
  - IDLE:
    - Accepted word with s_sof=1: op <= s_data[3:0]; invalid_data <= (s_data[WIDTH-1:4] != 0) || (s_data[3:0] >= NUM_OPS); go to GET_A.
    - Accepted word with s_sof=0: dropped, frame_err_cnt incremented, stay in IDLE.
  - GET_A:
    - Accepted word with s_sof=0: in1 <= s_data; go to GET_B.
    - Accepted word with s_sof=1: treated as a new opcode (op and invalid_data reloaded), frame_err_cnt incremented, stay in GET_A.
  - GET_B:
    - Accepted word with s_sof=0: in2 <= s_data; issue_valid <= 1; go to ISSUE.
    - Accepted word with s_sof=1: same restart handling as GET_A; go to GET_A.
  - ISSUE:
    - in1/in2/op/invalid_data/issue_valid are held stable until issue_valid && issue_ready.
    - On that handshake: issue_valid <= 0; go to IDLE.
- Latency: issue_valid rises on the clock edge that accepts operand 2.
- Throughput: 4 cycles per command minimum. The loader never accepts the next opcode in the same cycle as an issue handshake.
- Partial words: in1 and in2 are loaded only when their word is accepted. A restart leaves the previous in1/in2 values until they are overwritten.
- After issue, in1/in2/op/invalid_data retain their last values; they are not cleared.
- frame_err_cnt saturates at 2^CNT_W-1 and never wraps.
- Divide by zero is not checked here; the ALU owns that error.
- Reset mid-frame or mid-ISSUE: the partial or pending command is discarded, with reset values as above.
- Stalls: s_valid=0 in any state causes no state change. issue_ready is ignored outside ISSUE.

Test Plan:
- Reset release, then stream (sof=1,0x02), (0,0x05), (0,0xFD) with issue_ready=1 -> issue_valid high 1 cycle after the third word, with op=2, in1=5, in2=-3, invalid_data=0; back to IDLE; s_ready=0 only during ISSUE.
- Same frame with issue_ready=0 for 5 cycles -> outputs stable and s_ready=0 for 5 cycles; handshake on cycle 6; the next opcode is accepted the following cycle.
- Opcode word 0x07 with NUM_OPS=4, and separately word 0x13 -> invalid_data=1 in both cases, op=7 and op=3 respectively; the command still issues.
- Stream (0,0x11) in IDLE, then (1,0x01), (1,0x03), (0,0x0A), (0,0x02) -> frame_err_cnt=2; issued command has op=3, in1=10, in2=2.
- Send 300 stray sof=0 words in IDLE -> frame_err_cnt stops at 255 with no wrap.
- rst_n=0 for 1 cycle while in ISSUE with a pending command -> issue_valid=0 and all outputs are 0 the next cycle; a new frame then issues normally.

Source files
------------

// File: rtl/alu_cmd_loader.sv
`default_nettype none
// ============================================================================
// alu_cmd_loader : assembles {opcode, operand1, operand2} stream words into one ALU command
// Revision 1.0 : initial release
// ============================================================================
module alu_cmd_loader #(
   parameter int WIDTH   = 8,
   parameter int NUM_OPS = 4,
   parameter int CNT_W   = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] s_data,
   input  logic             s_sof,
   input  logic             s_valid,
   output logic             s_ready,
   output logic [WIDTH-1:0] in1,
   output logic [WIDTH-1:0] in2,
   output logic [3:0]       op,
   output logic             invalid_data,
   output logic             issue_valid,
   input  logic             issue_ready,
   output logic [CNT_W-1:0] frame_err_cnt
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GET_A = 2'd1,
      GET_B = 2'd2,
      ISSUE = 2'd3
   } state_t;

   // Opcodes are 4 bits wide, so more than 16 legal ops means every nibble is legal.
   localparam logic [4:0] C_NUM_OPS = (NUM_OPS > 16) ? 5'd16 : 5'(NUM_OPS);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] in1_q, in1_d;
   logic [WIDTH-1:0] in2_q, in2_d;
   logic [3:0]       op_q, op_d;
   logic             inv_q, inv_d;
   logic             valid_q, valid_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic accept;
   logic op_load;
   logic cnt_inc;
   logic hi_nz;
   logic op_bad;

   generate
      if (WIDTH > 4) begin : g_hi_bits
         assign hi_nz = |s_data[WIDTH-1:4];
      end else begin : g_no_hi_bits
         assign hi_nz = 1'b0;
      end
   endgenerate

   assign op_bad  = hi_nz || ({1'b0, s_data[3:0]} >= C_NUM_OPS);
   assign s_ready = rst_n && (state_q != ISSUE);
   assign accept  = s_valid && s_ready;

   always_comb begin
      state_d = state_q;
      in1_d   = in1_q;
      in2_d   = in2_q;
      op_d    = op_q;
      inv_d   = inv_q;
      valid_d = valid_q;
      cnt_d   = cnt_q;
      op_load = 1'b0;
      cnt_inc = 1'b0;

      case (state_q)
         IDLE: begin
            if (accept) begin
               if (s_sof) begin
                  op_load = 1'b1;
                  state_d = GET_A;
               end else begin
                  cnt_inc = 1'b1;
               end
            end
         end
         GET_A: begin
            if (accept) begin
               if (s_sof) begin
                  op_load = 1'b1;
                  cnt_inc = 1'b1;
               end else begin
                  in1_d   = s_data;
                  state_d = GET_B;
               end
            end
         end
         GET_B: begin
            if (accept) begin
               if (s_sof) begin
                  op_load = 1'b1;
                  cnt_inc = 1'b1;
                  state_d = GET_A;
               end else begin
                  in2_d   = s_data;
                  valid_d = 1'b1;
                  state_d = ISSUE;
               end
            end
         end
         ISSUE: begin
            if (issue_ready) begin
               valid_d = 1'b0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      if (op_load) begin
         op_d  = s_data[3:0];
         inv_d = op_bad;
      end
      // Saturate rather than wrap so a long burst of garbage stays visible.
      if (cnt_inc && (cnt_q != {CNT_W{1'b1}})) begin
         cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         in1_q   <= '0;
         in2_q   <= '0;
         op_q    <= '0;
         inv_q   <= 1'b0;
         valid_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         in1_q   <= in1_d;
         in2_q   <= in2_d;
         op_q    <= op_d;
         inv_q   <= inv_d;
         valid_q <= valid_d;
         cnt_q   <= cnt_d;
      end
   end

   assign in1           = in1_q;
   assign in2           = in2_q;
   assign op            = op_q;
   assign invalid_data  = inv_q;
   assign issue_valid   = valid_q;
   assign frame_err_cnt = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_cmd_loader.sv
`default_nettype none
// ============================================================================
// tb_alu_cmd_loader : table-driven and scoreboard bench for alu_cmd_loader
// Revision 1.0 : initial release
// ============================================================================
module tb_alu_cmd_loader;

   logic       clk;
   logic       rst_n;
   logic [7:0] s_data;
   logic       s_sof;
   logic       s_valid;
   logic       s_ready;
   logic [7:0] in1;
   logic [7:0] in2;
   logic [3:0] op;
   logic       invalid_data;
   logic       issue_valid;
   logic       issue_ready;
   logic [7:0] frame_err_cnt;

   alu_cmd_loader #(.WIDTH(8), .NUM_OPS(4), .CNT_W(8)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .s_data        (s_data),
      .s_sof         (s_sof),
      .s_valid       (s_valid),
      .s_ready       (s_ready),
      .in1           (in1),
      .in2           (in2),
      .op            (op),
      .invalid_data  (invalid_data),
      .issue_valid   (issue_valid),
      .issue_ready   (issue_ready),
      .frame_err_cnt (frame_err_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [3:0] op;
      logic [7:0] in1;
      logic [7:0] in2;
      logic       inv;
   } exp_t;

   typedef struct {
      logic [7:0] w0;
      logic [7:0] w1;
      logic [7:0] w2;
      logic [3:0] e_op;
      logic       e_inv;
   } vec_t;

   exp_t exp_q[$];
   int   checks   = 0;
   int   failures = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
      end
   endtask

   // Issue handshakes are seen on the falling edge before the accepting rising edge.
   always @(negedge clk) begin
      if (rst_n && issue_valid && issue_ready) begin
         if (exp_q.size() == 0) begin
            check("unexpected_issue", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("issue_op",  {28'd0, op}, {28'd0, e.op});
            check("issue_in1", {24'd0, in1}, {24'd0, e.in1});
            check("issue_in2", {24'd0, in2}, {24'd0, e.in2});
            check("issue_inv", {31'd0, invalid_data}, {31'd0, e.inv});
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_word(input logic sof, input logic [7:0] data, output int waited);
      waited  = 0;
      s_valid = 1'b1;
      s_sof   = sof;
      s_data  = data;
      while (!s_ready && waited < 20) begin
         tick();
         waited++;
      end
      if (!s_ready) begin
         check("send_timeout", 32'd1, 32'd0);
      end else begin
         tick();
      end
      s_valid = 1'b0;
      s_sof   = 1'b0;
   endtask

   task automatic send_frame(input logic [7:0] w0, input logic [7:0] w1, input logic [7:0] w2,
                             input logic [3:0] e_op, input logic e_inv);
      int   w;
      exp_t e;
      send_word(1'b1, w0, w);
      send_word(1'b0, w1, w);
      e.op  = e_op;
      e.in1 = w1;
      e.in2 = w2;
      e.inv = e_inv;
      exp_q.push_back(e);
      send_word(1'b0, w2, w);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vecs[6];
      int   w;
      exp_t e;

      vecs[0] = '{w0: 8'h07, w1: 8'h11, w2: 8'h22, e_op: 4'h7, e_inv: 1'b1};
      vecs[1] = '{w0: 8'h13, w1: 8'h33, w2: 8'h44, e_op: 4'h3, e_inv: 1'b1};
      vecs[2] = '{w0: 8'h00, w1: 8'h80, w2: 8'h7F, e_op: 4'h0, e_inv: 1'b0};
      vecs[3] = '{w0: 8'h03, w1: 8'hFF, w2: 8'h01, e_op: 4'h3, e_inv: 1'b0};
      vecs[4] = '{w0: 8'h04, w1: 8'h00, w2: 8'h00, e_op: 4'h4, e_inv: 1'b1};
      vecs[5] = '{w0: 8'hF0, w1: 8'h5A, w2: 8'hA5, e_op: 4'h0, e_inv: 1'b1};

      rst_n       = 1'b0;
      s_valid     = 1'b0;
      s_sof       = 1'b0;
      s_data      = 8'h00;
      issue_ready = 1'b1;
      tick();
      tick();
      check("rst_s_ready", {31'd0, s_ready}, 32'd0);
      check("rst_issue_valid", {31'd0, issue_valid}, 32'd0);
      check("rst_outputs", {in1, in2, op, 3'd0, invalid_data}, 32'd0);
      check("rst_cnt", {24'd0, frame_err_cnt}, 32'd0);
      rst_n = 1'b1;
      #1;
      check("idle_s_ready", {31'd0, s_ready}, 32'd1);

      // Basic frame, consumer always ready.
      send_frame(8'h02, 8'h05, 8'hFD, 4'h2, 1'b0);
      check("lat_issue_valid", {31'd0, issue_valid}, 32'd1);
      check("issue_s_ready", {31'd0, s_ready}, 32'd0);
      tick();
      check("post_issue_valid", {31'd0, issue_valid}, 32'd0);
      check("post_issue_s_ready", {31'd0, s_ready}, 32'd1);

      // Backpressure: hold for 5 cycles, handshake on the 6th.
      issue_ready = 1'b0;
      send_frame(8'h02, 8'h05, 8'hFD, 4'h2, 1'b0);
      for (int i = 0; i < 5; i++) begin
         check("stall_valid", {31'd0, issue_valid}, 32'd1);
         check("stall_s_ready", {31'd0, s_ready}, 32'd0);
         check("stall_data", {op, in1, in2, 3'd0, invalid_data}, {4'h2, 8'h05, 8'hFD, 4'd0});
         tick();
      end
      issue_ready = 1'b1;
      tick();
      send_word(1'b1, 8'h01, w);
      check("next_op_wait", w, 32'd0);
      send_word(1'b0, 8'h07, w);
      e = '{op: 4'h1, in1: 8'h07, in2: 8'h03, inv: 1'b0};
      exp_q.push_back(e);
      send_word(1'b0, 8'h03, w);

      for (int i = 0; i < 6; i++) begin
         send_frame(vecs[i].w0, vecs[i].w1, vecs[i].w2, vecs[i].e_op, vecs[i].e_inv);
      end
      tick();
      check("cnt_after_table", {24'd0, frame_err_cnt}, 32'd0);

      // Framing errors: stray word in IDLE and restart in GET_A.
      send_word(1'b0, 8'h11, w);
      check("cnt_stray", {24'd0, frame_err_cnt}, 32'd1);
      send_word(1'b1, 8'h01, w);
      send_word(1'b1, 8'h03, w);
      check("cnt_restart_a", {24'd0, frame_err_cnt}, 32'd2);
      send_word(1'b0, 8'h0A, w);
      e = '{op: 4'h3, in1: 8'h0A, in2: 8'h02, inv: 1'b0};
      exp_q.push_back(e);
      send_word(1'b0, 8'h02, w);

      // Restart from GET_B.
      send_word(1'b1, 8'h02, w);
      send_word(1'b0, 8'h04, w);
      send_word(1'b1, 8'h01, w);
      check("cnt_restart_b", {24'd0, frame_err_cnt}, 32'd3);
      send_word(1'b0, 8'h09, w);
      e = '{op: 4'h1, in1: 8'h09, in2: 8'h06, inv: 1'b0};
      exp_q.push_back(e);
      send_word(1'b0, 8'h06, w);
      tick();

      // Saturation of the error counter.
      for (int i = 0; i < 251; i++) send_word(1'b0, 8'h55, w);
      check("cnt_254", {24'd0, frame_err_cnt}, 32'd254);
      for (int i = 0; i < 49; i++) send_word(1'b0, 8'h55, w);
      check("cnt_saturated", {24'd0, frame_err_cnt}, 32'd255);

      // Reset while a command is pending in ISSUE.
      issue_ready = 1'b0;
      send_frame(8'h01, 8'h12, 8'h34, 4'h1, 1'b0);
      check("pending_valid", {31'd0, issue_valid}, 32'd1);
      void'(exp_q.pop_back());
      rst_n = 1'b0;
      tick();
      check("midrst_valid", {31'd0, issue_valid}, 32'd0);
      check("midrst_outputs", {in1, in2, op, 3'd0, invalid_data}, 32'd0);
      check("midrst_cnt", {24'd0, frame_err_cnt}, 32'd0);
      check("midrst_s_ready", {31'd0, s_ready}, 32'd0);
      rst_n       = 1'b1;
      issue_ready = 1'b1;
      #1;
      send_frame(8'h03, 8'hC0, 8'h0C, 4'h3, 1'b0);
      tick();
      tick();
      check("queue_empty", exp_q.size(), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
